// File: rtl/mc_control_if.sv
// Control bundle between the multi-cycle controller and its datapath.
// master = controller side, slave = datapath side.
interface mc_control_if;
  logic [5:0] Op;
  logic [5:0] Func;
  logic       Z;
  logic [1:0] Aluc;
  logic       AluSrcA;
  logic [1:0] AluSrcB;
  logic       ExtZero;
  logic       IorD;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemToReg;
  logic       RegWrite;
  logic [1:0] PCSrc;
  logic       PCWrite;
  logic [3:0] State;
  logic       Err;

  modport master (
    input  Op, Func, Z,
    output Aluc, AluSrcA, AluSrcB, ExtZero,
    output IorD, MemWrite, IRWrite,
    output RegDst, MemToReg, RegWrite,
    output PCSrc, PCWrite, State, Err
  );

  modport slave (
    output Op, Func, Z,
    input  Aluc, AluSrcA, AluSrcB, ExtZero,
    input  IorD, MemWrite, IRWrite,
    input  RegDst, MemToReg, RegWrite,
    input  PCSrc, PCWrite, State, Err
  );
endinterface

// File: rtl/mc_control.sv
// Multi-cycle MIPS-subset main controller.
// Sequences each instruction and drives all datapath selects/enables.
module mc_control (
  input logic          Clk,
  input logic          Rst,
  mc_control_if.master bus
);

  localparam logic [3:0] FETCH  = 4'd0;
  localparam logic [3:0] DECODE = 4'd1;
  localparam logic [3:0] MEMADR = 4'd2;
  localparam logic [3:0] MEMRD  = 4'd3;
  localparam logic [3:0] MEMWB  = 4'd4;
  localparam logic [3:0] MEMWR  = 4'd5;
  localparam logic [3:0] EXEC_R = 4'd6;
  localparam logic [3:0] ALUWB  = 4'd7;
  localparam logic [3:0] EXEC_I = 4'd8;
  localparam logic [3:0] BRANCH = 4'd9;
  localparam logic [3:0] JUMP   = 4'd10;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;

  logic [3:0] state;
  logic [3:0] nxt;
  logic       err;
  logic       set_err;

  logic is_r, fn_ok, is_mem, is_ari;
  logic is_br, is_j;

  assign fn_ok  = (bus.Func == FN_ADD) || (bus.Func == FN_SUB) ||
                  (bus.Func == FN_AND) || (bus.Func == FN_OR);
  assign is_r   = (bus.Op == OP_R) && fn_ok;
  assign is_mem = (bus.Op == OP_LW) || (bus.Op == OP_SW);
  assign is_ari = (bus.Op == OP_ADDI) || (bus.Op == OP_ANDI) ||
                  (bus.Op == OP_ORI);
  assign is_br  = (bus.Op == OP_BEQ) || (bus.Op == OP_BNE);
  assign is_j   = (bus.Op == OP_J);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= FETCH;
      err   <= 1'b0;
    end else begin
      state <= nxt;
      if (set_err) err <= 1'b1;
    end
  end

  always_comb begin
    nxt     = FETCH;
    set_err = 1'b0;
    case (state)
      FETCH: nxt = DECODE;
      DECODE: begin
        unique case (1'b1)
          is_mem:  nxt = MEMADR;
          is_r:    nxt = EXEC_R;
          is_ari:  nxt = EXEC_I;
          is_br:   nxt = BRANCH;
          is_j:    nxt = JUMP;
          default: set_err = 1'b1;
        endcase
      end
      MEMADR: nxt = (bus.Op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:  nxt = MEMWB;
      EXEC_R: nxt = ALUWB;
      EXEC_I: nxt = ALUWB;
      MEMWB, MEMWR, ALUWB, BRANCH, JUMP: nxt = FETCH;
      default: set_err = 1'b1;
    endcase
  end

  // Write enables are built first, then gated by Rst below.
  logic pc_we, ir_we, mem_we, reg_we;

  always_comb begin
    bus.Aluc     = 2'b00;
    bus.AluSrcA  = 1'b0;
    bus.AluSrcB  = 2'b00;
    bus.ExtZero  = 1'b0;
    bus.IorD     = 1'b0;
    bus.RegDst   = 1'b0;
    bus.MemToReg = 1'b0;
    bus.PCSrc    = 2'b00;
    pc_we        = 1'b0;
    ir_we        = 1'b0;
    mem_we       = 1'b0;
    reg_we       = 1'b0;
    case (state)
      FETCH: begin
        bus.AluSrcB = 2'b01;
        ir_we       = 1'b1;
        pc_we       = 1'b1;
      end
      DECODE: bus.AluSrcB = 2'b11;
      MEMADR: begin
        bus.AluSrcA = 1'b1;
        bus.AluSrcB = 2'b10;
      end
      MEMRD: bus.IorD = 1'b1;
      MEMWB: begin
        bus.MemToReg = 1'b1;
        reg_we       = 1'b1;
      end
      MEMWR: begin
        bus.IorD = 1'b1;
        mem_we   = 1'b1;
      end
      EXEC_R: begin
        bus.AluSrcA = 1'b1;
        unique case (1'b1)
          bus.Func == FN_SUB: bus.Aluc = 2'b01;
          bus.Func == FN_AND: bus.Aluc = 2'b10;
          bus.Func == FN_OR:  bus.Aluc = 2'b11;
          default:            bus.Aluc = 2'b00;
        endcase
      end
      ALUWB: begin
        bus.RegDst = (bus.Op == OP_R);
        reg_we     = 1'b1;
      end
      EXEC_I: begin
        bus.AluSrcA = 1'b1;
        bus.AluSrcB = 2'b10;
        unique case (1'b1)
          bus.Op == OP_ANDI: begin
            bus.Aluc    = 2'b10;
            bus.ExtZero = 1'b1;
          end
          bus.Op == OP_ORI: begin
            bus.Aluc    = 2'b11;
            bus.ExtZero = 1'b1;
          end
          default: bus.Aluc = 2'b00;
        endcase
      end
      BRANCH: begin
        bus.AluSrcA = 1'b1;
        bus.Aluc    = 2'b01;
        bus.PCSrc   = 2'b01;
        pc_we = ((bus.Op == OP_BEQ) && bus.Z) ||
                ((bus.Op == OP_BNE) && !bus.Z);
      end
      JUMP: begin
        bus.PCSrc = 2'b10;
        pc_we     = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.PCWrite  = pc_we  & ~Rst;
  assign bus.IRWrite  = ir_we  & ~Rst;
  assign bus.MemWrite = mem_we & ~Rst;
  assign bus.RegWrite = reg_we & ~Rst;
  assign bus.State    = state;
  assign bus.Err      = err;

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: walks each instruction class
// through its state sequence and checks the control outputs.
module tb_mc_control;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  mc_control_if b ();

  mc_control dut (
    .Clk (clk),
    .Rst (rst),
    .bus (b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] we();
    return {4'b0, b.PCWrite, b.IRWrite, b.MemWrite, b.RegWrite};
  endfunction

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst    = 1'b1;
    b.Op   = 6'b000000;
    b.Func = 6'b100000;
    b.Z    = 1'b0;
    #2;
    chk("rst_state", {4'b0, b.State}, 8'd0);
    chk("rst_err", {7'b0, b.Err}, 8'd0);
    chk("rst_we", we(), 8'h0);
    chk("rst_srcb", {6'b0, b.AluSrcB}, 8'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_we", we(), 8'b1100);

    // add
    step(); chk("add_s1", {4'b0, b.State}, 8'd1);
    chk("dec_srcb", {6'b0, b.AluSrcB}, 8'd3);
    step(); chk("add_s6", {4'b0, b.State}, 8'd6);
    chk("add_aluc", {6'b0, b.Aluc}, 8'd0);
    chk("add_s6_we", we(), 8'h0);
    step(); chk("add_s7", {4'b0, b.State}, 8'd7);
    chk("add_rd", {7'b0, b.RegDst}, 8'd1);
    chk("add_s7_we", we(), 8'b0001);
    step(); chk("add_s0", {4'b0, b.State}, 8'd0);
    chk("add_s0_rw", {7'b0, b.RegWrite}, 8'd0);

    // sub
    b.Func = 6'b100010;
    step(); step(); chk("sub_s6", {4'b0, b.State}, 8'd6);
    chk("sub_aluc", {6'b0, b.Aluc}, 8'd1);
    step(); step(); chk("sub_s0", {4'b0, b.State}, 8'd0);

    // lw
    b.Op = 6'b100011;
    step(); chk("lw_s1", {4'b0, b.State}, 8'd1);
    step(); chk("lw_s2", {4'b0, b.State}, 8'd2);
    chk("lw_srcb", {6'b0, b.AluSrcB}, 8'd2);
    step(); chk("lw_s3", {4'b0, b.State}, 8'd3);
    chk("lw_iord", {7'b0, b.IorD}, 8'd1);
    step(); chk("lw_s4", {4'b0, b.State}, 8'd4);
    chk("lw_m2r", {7'b0, b.MemToReg}, 8'd1);
    chk("lw_we", we(), 8'b0001);
    step(); chk("lw_s0", {4'b0, b.State}, 8'd0);

    // sw
    b.Op = 6'b101011;
    step(); step(); chk("sw_s2", {4'b0, b.State}, 8'd2);
    chk("sw_s2_we", we(), 8'h0);
    step(); chk("sw_s5", {4'b0, b.State}, 8'd5);
    chk("sw_we", we(), 8'b0010);
    step(); chk("sw_s0", {4'b0, b.State}, 8'd0);
    chk("sw_s0_mw", {7'b0, b.MemWrite}, 8'd0);

    // beq, with Z toggled during FETCH
    b.Op = 6'b000100;
    b.Z = 1'b1; #1;
    chk("f_z1_pcw", {7'b0, b.PCWrite}, 8'd1);
    b.Z = 1'b0; #1;
    chk("f_z0_pcw", {7'b0, b.PCWrite}, 8'd1);
    step(); step(); chk("beq_s9", {4'b0, b.State}, 8'd9);
    b.Z = 1'b1; #1;
    chk("beq_z1_pcw", {7'b0, b.PCWrite}, 8'd1);
    chk("beq_pcsrc", {6'b0, b.PCSrc}, 8'd1);
    chk("beq_aluc", {6'b0, b.Aluc}, 8'd1);
    b.Z = 1'b0; #1;
    chk("beq_z0_pcw", {7'b0, b.PCWrite}, 8'd0);
    step(); chk("beq_s0", {4'b0, b.State}, 8'd0);

    // bne
    b.Op = 6'b000101;
    step(); step(); chk("bne_s9", {4'b0, b.State}, 8'd9);
    b.Z = 1'b1; #1;
    chk("bne_z1_pcw", {7'b0, b.PCWrite}, 8'd0);
    b.Z = 1'b0; #1;
    chk("bne_z0_pcw", {7'b0, b.PCWrite}, 8'd1);
    step(); chk("bne_s0", {4'b0, b.State}, 8'd0);

    // j
    b.Op = 6'b000010;
    step(); step(); chk("j_s10", {4'b0, b.State}, 8'd10);
    chk("j_pcsrc", {6'b0, b.PCSrc}, 8'd2);
    chk("j_we", we(), 8'b1000);
    step(); chk("j_s0", {4'b0, b.State}, 8'd0);

    // ori
    b.Op = 6'b001101;
    step(); step(); chk("ori_s8", {4'b0, b.State}, 8'd8);
    chk("ori_ext", {7'b0, b.ExtZero}, 8'd1);
    chk("ori_aluc", {6'b0, b.Aluc}, 8'd3);
    step(); chk("ori_s7", {4'b0, b.State}, 8'd7);
    chk("ori_rd", {7'b0, b.RegDst}, 8'd0);
    chk("ori_rw", {7'b0, b.RegWrite}, 8'd1);
    step(); chk("ori_s0", {4'b0, b.State}, 8'd0);
    chk("ori_err", {7'b0, b.Err}, 8'd0);

    // illegal opcode
    b.Op = 6'b111111;
    step(); chk("ill_s1", {4'b0, b.State}, 8'd1);
    chk("ill_we", we(), 8'h0);
    chk("ill_err_pre", {7'b0, b.Err}, 8'd0);
    step(); chk("ill_s0", {4'b0, b.State}, 8'd0);
    chk("ill_err", {7'b0, b.Err}, 8'd1);

    // valid add after illegal: Err sticks
    b.Op = 6'b000000;
    b.Func = 6'b100000;
    step(); chk("pa_s1", {4'b0, b.State}, 8'd1);
    step(); chk("pa_s6", {4'b0, b.State}, 8'd6);
    step(); step(); chk("pa_s0", {4'b0, b.State}, 8'd0);
    chk("pa_err", {7'b0, b.Err}, 8'd1);

    // reset mid-EXEC_R
    step(); step(); chk("mr_s6", {4'b0, b.State}, 8'd6);
    rst = 1'b1; #1;
    chk("mr_state", {4'b0, b.State}, 8'd0);
    chk("mr_err", {7'b0, b.Err}, 8'd0);
    chk("mr_we", we(), 8'h0);
    step();
    chk("mr_hold_st", {4'b0, b.State}, 8'd0);
    chk("mr_hold_we", we(), 8'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mr_rel_we", we(), 8'b1100);
    step(); chk("mr_s1", {4'b0, b.State}, 8'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mc_control.md
# mc_control

Multi-cycle main controller for the team's multi-cycle MIPS-subset CPU. It decodes the instruction register's Op/Func fields, sequences each instruction through 3–5 clock states, and drives every datapath select and write enable. It produces the 2-bit ALU operation code that the ALU consumes, and consumes the ALU's Z flag to resolve branches.

## Interface
- No parameters. Opcodes, funct codes and the ALU encoding are fixed.
- Clk  in  1  system clock, rising-edge.
- Rst  in  1  reset, asynchronous, active-high.
- Op  in  6  IR[31:26].
- Func  in  6  IR[5:0].
- Z  in  1  ALU zero flag, combinational from the current ALU result.
- Aluc  out  2  ALU operation: 00 add, 01 sub, 10 and, 11 or.
- AluSrcA  out  1  ALU A input select: 0 PC, 1 register A.
- AluSrcB  out  2  ALU B input select: 00 register B, 01 constant 4, 10 extended imm, 11 sign-ext imm<<2.
- ExtZero  out  1  imm extension: 1 zero-extend, 0 sign-extend.
- IorD  out  1  memory address select: 0 PC, 1 ALUOut.
- MemWrite  out  1  data memory write.
- IRWrite  out  1  IR load.
- RegDst  out  1  destination register: 0 rt, 1 rd.
- MemToReg  out  1  writeback source: 0 ALUOut, 1 MDR.
- RegWrite  out  1  register file write.
- PCSrc  out  2  next-PC source: 00 ALU result, 01 ALUOut, 10 {PC[31:28],IR[25:0],2'b00}.
- PCWrite  out  1  PC load (branch condition already folded in).
- State  out  4  current state, for debug.
- Err  out  1  sticky illegal-instruction flag.

## Operation
- Supported instructions and codes:
  - R-type (Op 000000) with Func 100000 add, 100010 sub, 100100 and, 100101 or.
  - addi 001000, andi 001100, ori 001101.
  - lw 100011, sw 101011.
  - beq 000100, bne 000101.
  - j 000010.
- States and encoding, with asserted outputs. Any output not listed is 0; don't-care selects are also driven 0.
  - FETCH(0): IorD=0, IRWrite, AluSrcA=0, AluSrcB=01, Aluc=00, PCSrc=00, PCWrite. Next is DECODE.
  - DECODE(1): AluSrcA=0, AluSrcB=11, Aluc=00 (branch target into ALUOut). Next by Op:
    - lw/sw go to MEMADR.
    - R-type goes to EXEC_R.
    - addi/andi/ori go to EXEC_I.
    - beq/bne go to BRANCH.
    - j goes to JUMP.
    - Anything else, including R-type with an unlisted Func, goes to FETCH and sets Err.
  - MEMADR(2): AluSrcA=1, AluSrcB=10, ExtZero=0, Aluc=00. Next is MEMRD for lw, MEMWR for sw.
  - MEMRD(3): IorD=1. Next is MEMWB.
  - MEMWB(4): RegDst=0, MemToReg=1, RegWrite. Next is FETCH.
  - MEMWR(5): IorD=1, MemWrite. Next is FETCH.
  - EXEC_R(6): AluSrcA=1, AluSrcB=00, Aluc by Func (add 00, sub 01, and 10, or 11). Next is ALUWB.
  - ALUWB(7): RegDst=1 if Op=000000 else 0, MemToReg=0, RegWrite. Next is FETCH.
  - EXEC_I(8): AluSrcA=1, AluSrcB=10, Aluc/ExtZero = addi 00/0, andi 10/1, ori 11/1. Next is ALUWB.
  - BRANCH(9): AluSrcA=1, AluSrcB=00, Aluc=01, PCSrc=01. PCWrite = (beq & Z) | (bne & ~Z). Next is FETCH.
  - JUMP(10): PCSrc=10, PCWrite. Next is FETCH.
- Unused encodings 11–15 go to FETCH on the next edge, set Err, and assert no write enables.
- Outputs are Moore (decoded from State, Op, Func), except BRANCH PCWrite, which depends combinationally on Z.
- Op/Func are sampled from IR, which is stable after FETCH. The controller does not latch them.

## Timing
- Cycles per instruction: lw 5, sw 4, R-type 4, I-arith 4, beq/bne 3, j 3, illegal 2.
- State register updates on the rising Clk edge. Err sets on the same edge that leaves DECODE or an unused state, and clears only on Rst.
- Rst=1 forces State=FETCH and Err=0 immediately (asynchronous). While Rst=1:
  - PCWrite, IRWrite, MemWrite and RegWrite are forced 0.
  - All other outputs show their FETCH values.
- First FETCH write happens on the first rising edge after Rst falls.
- Reset asserted mid-instruction abandons it. No partial write may occur after Rst rises, including in MEMWR/MEMWB/ALUWB.
- Z is used only in BRANCH. Z glitches in other states have no effect.

## Test plan
- Reset: assert Rst mid-EXEC_R.
  - Required: State=0 and Err=0 immediately; all write enables 0 while Rst=1.
  - After release: IRWrite=1, PCWrite=1 on the first cycle.
- add (Op 000000, Func 100000) from reset.
  - Required State sequence 0,1,6,7,0.
  - Aluc=00 in state 6; RegDst=1 and RegWrite=1 in state 7 only.
  - Repeat with sub → Aluc=01.
- lw then sw.
  - lw required sequence 0,1,2,3,4: IorD=1 in state 3; MemToReg=1 and RegWrite=1 in state 4.
  - sw required sequence 0,1,2,5: MemWrite=1 only in state 5.
- beq in BRANCH.
  - Z=1: PCWrite=1, PCSrc=01, Aluc=01.
  - Z=0: PCWrite=0.
  - bne: the inverse of both cases.
  - Toggle Z during FETCH: no effect on PCWrite.
- ori (001101).
  - Required sequence 0,1,8,7: ExtZero=1, Aluc=11 in state 8; RegDst=0 in state 7.
- Illegal handling.
  - Op 111111 → sequence 0,1,0, Err=1 after the DECODE edge, no write enable asserted in the DECODE cycle.
  - Err stays 1 across a following valid add.
  - Err clears only on Rst.
